// File: rtl/cpg_pkg.sv
// Shared constants for the count pulse generator:
// FSM encodings, default timing, LED decode.
package cpg_pkg;

  localparam int PULSE_HI_DEF = 4;
  localparam int PULSE_LO_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  function automatic logic [2:0] therm(
    input logic [1:0] c
  );
    logic [2:0] t;
    unique case (c)
      2'd0: t = 3'b000;
      2'd1: t = 3'b001;
      2'd2: t = 3'b011;
      default: t = 3'b111;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/count_pulse_gen_if.sv
// Button, count and status bundle for
// count_pulse_gen.
interface count_pulse_gen_if;
  logic       SW_START;
  logic [1:0] CNT;
  logic       PULSE;
  logic       BUSY;
  logic       DONE;
  logic [2:0] LED;

  modport master (
    output SW_START, CNT,
    input  PULSE, BUSY, DONE, LED
  );

  modport slave (
    input  SW_START, CNT,
    output PULSE, BUSY, DONE, LED
  );
endinterface

// File: rtl/btn_sync_edge.sv
// Active-low button synchronizer with a
// registered falling-edge strobe.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;
  logic v1_q, v1_d;
  logic v2_q, v2_d;
  logic armed_q, armed_d;
  logic fall_q, fall_d;

  // v1/v2 mark when s2 holds a real sample;
  // arming needs a genuine release first, so a
  // button held through reset never fires.
  always_comb begin
    s1_d    = btn_n;
    s2_d    = s1_q;
    prev_d  = s2_q;
    v1_d    = 1'b1;
    v2_d    = v1_q;
    armed_d = armed_q | (v2_q & s2_q);
    fall_d  = armed_q & prev_q & ~s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      armed_q <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      armed_q <= armed_d;
      fall_q  <= fall_d;
    end
  end

  assign fall = fall_q;

endmodule

// File: rtl/count_pulse_gen.sv
// Emits CNT unary pulses per button press,
// with busy/done status and a thermometer LED.
module count_pulse_gen
  import cpg_pkg::*;
#(
  parameter int PULSE_HI = PULSE_HI_DEF,
  parameter int PULSE_LO = PULSE_LO_DEF
) (
  input  logic CLK,
  input  logic RSTN,
  count_pulse_gen_if.slave bus
);

  localparam logic [7:0] HI_LD = 8'(PULSE_HI - 1);
  localparam logic [7:0] LO_LD = 8'(PULSE_LO - 1);

  logic       start;
  logic [1:0] state_q, state_d;
  logic [7:0] tmr_q, tmr_d;
  logic [1:0] rem_q, rem_d;
  logic [2:0] led_q, led_d;
  logic       pulse_q, pulse_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tdone;

  btn_sync_edge u_sync (
    .clk   (CLK),
    .rst_n (RSTN),
    .btn_n (bus.SW_START),
    .fall  (start)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    led_d   = led_q;
    tdone   = (tmr_q == 8'd0);
    tmr_d   = tdone ? tmr_q : tmr_q - 8'd1;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (start) begin
          rem_d = bus.CNT;
          led_d = therm(bus.CNT);
          if (bus.CNT == 2'd0) begin
            state_d = ST_FIN;
            tmr_d   = 8'd0;
          end else begin
            state_d = ST_HIGH;
            tmr_d   = HI_LD;
          end
        end
      end
      (state_q == ST_HIGH): begin
        if (tdone) begin
          state_d = ST_LOW;
          tmr_d   = LO_LD;
          rem_d   = rem_q - 2'd1;
        end
      end
      (state_q == ST_LOW): begin
        if (tdone) begin
          if (rem_q != 2'd0) begin
            state_d = ST_HIGH;
            tmr_d   = HI_LD;
          end else begin
            state_d = ST_FIN;
            tmr_d   = 8'd0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = 8'd0;
      end
    endcase
    pulse_d = (state_d == ST_HIGH);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_FIN);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      tmr_q   <= 8'd0;
      rem_q   <= 2'd0;
      led_q   <= 3'b000;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      rem_q   <= rem_d;
      led_q   <= led_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.PULSE = pulse_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
  assign bus.LED   = led_q;

endmodule

// File: tb/tb_count_pulse_gen.sv
// Directed bench: default timing on u0,
// 1/1 timing on u1.
module tb_count_pulse_gen;
  import cpg_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  count_pulse_gen_if b0();
  count_pulse_gen_if b1();

  count_pulse_gen u0 (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (b0.slave)
  );

  count_pulse_gen #(
    .PULSE_HI (1),
    .PULSE_LO (1)
  ) u1 (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (b1.slave)
  );

  int vecs = 0;
  int errs = 0;
  logic [63:0] op, ob, od;
  logic [63:0] ep, eb, ed;
  logic [2:0]  oled;

  task automatic set_sw(input bit w, input logic v);
    if (w) b1.SW_START = v;
    else   b0.SW_START = v;
  endtask

  task automatic set_cnt(input bit w, input logic [1:0] v);
    if (w) b1.CNT = v;
    else   b0.CNT = v;
  endtask

  // Records one sample per cycle, taken at the
  // negedge after rising edge i; press lands
  // just after edge 0.
  task automatic obs(
    input bit w, input int n, input bit press,
    input int rel_at, input int press2_at,
    input int rst_at, input int rst_rel_at,
    input int cnt0_at
  );
    op = '0; ob = '0; od = '0;
    @(posedge clk); #1;
    if (press) set_sw(w, 1'b0);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (i == rel_at)     set_sw(w, 1'b1);
      if (i == press2_at)  set_sw(w, 1'b0);
      if (i == rst_at)     rstn = 1'b0;
      if (i == rst_rel_at) rstn = 1'b1;
      if (i == cnt0_at)    set_cnt(w, 2'd0);
      @(negedge clk);
      op[i] = w ? b1.PULSE : b0.PULSE;
      ob[i] = w ? b1.BUSY  : b0.BUSY;
      od[i] = w ? b1.DONE  : b0.DONE;
    end
    oled = w ? b1.LED : b0.LED;
  endtask

  task automatic exp_burst(
    input int first, input int hi, input int lo,
    input int cnt
  );
    int per;
    per = hi + lo;
    ep = '0; eb = '0; ed = '0;
    for (int k = 0; k < cnt; k++)
      for (int j = 0; j < hi; j++)
        ep[first + k*per + j] = 1'b1;
    for (int j = 0; j <= cnt*per; j++)
      eb[first + j] = 1'b1;
    ed[first + cnt*per] = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vecs++;
    if (b0.PULSE !== 1'b0) begin
      errs++; $display("FAIL rst_pulse0 got %b want 0", b0.PULSE);
    end
    vecs++;
    if (b0.BUSY !== 1'b0) begin
      errs++; $display("FAIL rst_busy0 got %b want 0", b0.BUSY);
    end
    vecs++;
    if (b0.DONE !== 1'b0) begin
      errs++; $display("FAIL rst_done0 got %b want 0", b0.DONE);
    end
    vecs++;
    if (b0.LED !== 3'b000) begin
      errs++; $display("FAIL rst_led0 got %b want 000", b0.LED);
    end
    vecs++;
    if (b1.PULSE !== 1'b0 || b1.BUSY !== 1'b0) begin
      errs++;
      $display("FAIL rst_u1 got p=%b b=%b want 0 0",
               b1.PULSE, b1.BUSY);
    end
    @(posedge clk); #1 rstn = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic test_burst3;
    set_cnt(0, 2'd3);
    obs(0, 40, 1, 10, -1, -1, -1, 8);
    exp_burst(4, 4, 4, 3);
    vecs++;
    if (op !== ep) begin
      errs++; $display("FAIL t1_pulse got %h want %h", op, ep);
    end
    vecs++;
    if (ob !== eb) begin
      errs++; $display("FAIL t1_busy got %h want %h", ob, eb);
    end
    vecs++;
    if (od !== ed) begin
      errs++; $display("FAIL t1_done got %h want %h", od, ed);
    end
    vecs++;
    if (oled !== 3'b111) begin
      errs++; $display("FAIL t1_led got %b want 111", oled);
    end
  endtask

  task automatic test_zero;
    set_cnt(0, 2'd0);
    obs(0, 20, 1, 3, -1, -1, -1, -1);
    exp_burst(4, 4, 4, 0);
    vecs++;
    if (op !== ep) begin
      errs++; $display("FAIL t2_pulse got %h want %h", op, ep);
    end
    vecs++;
    if (ob !== eb) begin
      errs++; $display("FAIL t2_busy got %h want %h", ob, eb);
    end
    vecs++;
    if (od !== ed) begin
      errs++; $display("FAIL t2_done got %h want %h", od, ed);
    end
    vecs++;
    if (oled !== 3'b000) begin
      errs++; $display("FAIL t2_led got %b want 000", oled);
    end
  endtask

  task automatic test_back_to_back;
    set_cnt(0, 2'd2);
    obs(0, 40, 1, 2, 4, -1, -1, -1);
    set_sw(0, 1'b1);
    repeat (6) @(posedge clk);
    exp_burst(4, 4, 4, 2);
    vecs++;
    if (op !== ep) begin
      errs++; $display("FAIL t3_pulse got %h want %h", op, ep);
    end
    vecs++;
    if (od !== ed) begin
      errs++; $display("FAIL t3_done got %h want %h", od, ed);
    end
    vecs++;
    if (oled !== 3'b011) begin
      errs++; $display("FAIL t3_led got %b want 011", oled);
    end
  endtask

  task automatic test_reset_mid;
    set_cnt(0, 2'd3);
    obs(0, 40, 1, 10, -1, 13, 16, -1);
    ep = '0; eb = '0; ed = '0;
    for (int i = 4; i <= 7; i++) ep[i] = 1'b1;
    ep[12] = 1'b1;
    for (int i = 4; i <= 12; i++) eb[i] = 1'b1;
    vecs++;
    if (op !== ep) begin
      errs++; $display("FAIL t4_pulse got %h want %h", op, ep);
    end
    vecs++;
    if (ob !== eb) begin
      errs++; $display("FAIL t4_busy got %h want %h", ob, eb);
    end
    vecs++;
    if (od !== ed) begin
      errs++; $display("FAIL t4_done got %h want %h", od, ed);
    end
    vecs++;
    if (oled !== 3'b000) begin
      errs++; $display("FAIL t4_led got %b want 000", oled);
    end
  endtask

  task automatic test_fast;
    set_cnt(1, 2'd1);
    obs(1, 20, 1, 3, -1, -1, -1, -1);
    exp_burst(4, 1, 1, 1);
    vecs++;
    if (op !== ep) begin
      errs++; $display("FAIL t5_pulse got %h want %h", op, ep);
    end
    vecs++;
    if (ob !== eb) begin
      errs++; $display("FAIL t5_busy got %h want %h", ob, eb);
    end
    vecs++;
    if (od !== ed) begin
      errs++; $display("FAIL t5_done got %h want %h", od, ed);
    end
    vecs++;
    if (oled !== 3'b001) begin
      errs++; $display("FAIL t5_led got %b want 001", oled);
    end
  endtask

  task automatic test_held_reset;
    set_cnt(0, 2'd1);
    set_sw(0, 1'b0);
    @(posedge clk); #1 rstn = 1'b0;
    obs(0, 20, 0, -1, -1, -1, 2, -1);
    vecs++;
    if ((op | ob | od) !== 64'd0) begin
      errs++;
      $display("FAIL t6_held got p=%h b=%h d=%h want 0",
               op, ob, od);
    end
    obs(0, 10, 0, 1, -1, -1, -1, -1);
    obs(0, 30, 1, 5, -1, -1, -1, -1);
    exp_burst(4, 4, 4, 1);
    vecs++;
    if (op !== ep) begin
      errs++; $display("FAIL t6_pulse got %h want %h", op, ep);
    end
    vecs++;
    if (od !== ed) begin
      errs++; $display("FAIL t6_done got %h want %h", od, ed);
    end
    vecs++;
    if (oled !== 3'b001) begin
      errs++; $display("FAIL t6_led got %b want 001", oled);
    end
  endtask

  initial begin
    rstn = 1'b0;
    b0.SW_START = 1'b1;
    b1.SW_START = 1'b1;
    b0.CNT = 2'd0;
    b1.CNT = 2'd0;
    test_reset;
    test_burst3;
    test_zero;
    test_back_to_back;
    test_reset_mid;
    test_fast;
    test_held_reset;
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/count_pulse_gen.md
COUNT_PULSE_GEN -- requirements
Module: count_pulse_gen

Interface
REQ-001 Parameter PULSE_HI, default 4: PULSE high time, in CLK cycles; legal range 1..255.
REQ-002 Parameter PULSE_LO, default 4: PULSE low time between pulses, in CLK cycles; legal range 1..255.
REQ-003 CLK  input  1  single system clock; all state changes on the rising edge.
REQ-004 RSTN  input  1  asynchronous, active-low reset.
REQ-005 SW_START  input  1  active-low start pushbutton; asynchronous to CLK.
REQ-006 CNT  input  2  count to transmit, 0..3; sampled only at accepted start.
REQ-007 PULSE  output  1  serial unary output, one high pulse per unit of count.
REQ-008 BUSY  output  1  high while a burst is in progress.
REQ-009 DONE  output  1  one-cycle strobe at burst end.
REQ-010 LED  output  3  thermometer display of the latched count, active-high.

Function
REQ-011 SW_START shall pass through a 2-flop synchronizer, then a falling-edge detector; one detected edge is one start request.
REQ-012 The FSM shall have exactly four states: IDLE, HIGH, LOW, FIN.
REQ-013 In IDLE, a start request shall latch CNT into a 2-bit remaining counter and into the LED register.
REQ-014 In IDLE, a start request with CNT=0 shall go to FIN; with CNT>0 it shall go to HIGH.
REQ-015 In HIGH, PULSE shall be 1 for exactly PULSE_HI cycles; the state then shall go to LOW and the remaining counter shall decrement by 1.
REQ-016 In LOW, PULSE shall be 0 for exactly PULSE_LO cycles; the state then shall go to HIGH if remaining>0, else to FIN.
REQ-017 FIN shall last one cycle with DONE=1, then return to IDLE.
REQ-018 BUSY shall be 1 in HIGH, LOW and FIN, and 0 in IDLE.
REQ-019 Start requests outside IDLE shall be ignored and shall not be queued.
REQ-020 A burst of count N shall produce exactly N pulses and occupy N*(PULSE_HI+PULSE_LO)+1 cycles from the first HIGH cycle through FIN.
REQ-021 Latency: the first HIGH cycle shall begin on the 4th rising CLK edge after SW_START is first sampled low (2 sync stages, 1 edge register, 1 state register).
REQ-022 LED shall be derived from the latched count as follows: 0 -> 000, 1 -> 001, 2 -> 011, 3 -> 111. LED shall hold until the next accepted start.
REQ-023 The phase timer shall be 8 bits wide, count down, reload on every state entry, and never wrap.
REQ-024 Changes on CNT while BUSY=1 shall have no effect.
REQ-025 PULSE, BUSY and DONE shall be registered outputs; none shall be combinational from an input.

Reset
REQ-026 Asserting RSTN low shall immediately force the following: state=IDLE, PULSE=0, BUSY=0, DONE=0, LED=000, timer=0, remaining=0, synchronizer and edge flops=1 (button released).
REQ-027 A reset asserted mid-burst shall abort the burst with no DONE strobe; no pulse shall appear after RSTN deasserts until a new start request.
REQ-028 A button held low through reset deassertion shall not produce a start request; only a new high-to-low transition starts a burst.

Structure
REQ-029 State encodings and the default PULSE_HI and PULSE_LO values shall be defined in the shared package cpg_pkg.
REQ-030 The synchronizer and falling-edge detector shall be one sub-module, btn_sync_edge, reusable for the other SW inputs.
REQ-031 The FSM, timer and counters shall live in count_pulse_gen; the expected implementation size is about 150-250 RTL lines.

Verification
REQ-032 Test 1: CNT=3, SW_START low for 10 cycles, defaults -> 3 PULSE highs of 4 cycles each, 4-cycle gaps; DONE 1 cycle; BUSY for 25 cycles; LED=111.
REQ-033 Test 2: CNT=0 start -> no PULSE; BUSY and DONE high for 1 cycle together; LED=000.
REQ-034 Test 3: CNT=2 start, then a second SW_START press during the first pulse -> exactly 2 pulses total, a single DONE.
REQ-035 Test 4: CNT=3 start, RSTN low during the second pulse -> PULSE=0 and BUSY=0 immediately; no DONE; idle after release.
REQ-036 Test 5: PULSE_HI=1, PULSE_LO=1, CNT=1 -> a 1-cycle pulse, then 1 low cycle, then DONE; first HIGH cycle on the 4th edge after SW_START is sampled low.
REQ-037 Test 6: SW_START held low across reset release -> no burst; a subsequent release and re-press with CNT=1 -> 1 pulse.
